rgb_pwm_driver: RTL and testbench



---
 rtl/rgb_pkg.sv | 23 ++
 rtl/pwm_channel.sv | 55 +++++
 rtl/rgb_pwm_driver.sv | 91 +++++++++
 tb/tb_rgb_pwm_driver.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/rgb_pkg.sv
// Shared definitions for the RGB colour-fade path: default PWM period, duty type,
// channel enumeration and the duty clamp helper used by every PWM channel.
package rgb_pkg;

    localparam int PWM_INTERVAL_DEFAULT = 1200;
    localparam int PWM_VAL_W            = $clog2(PWM_INTERVAL_DEFAULT);
    localparam int NUM_CH               = 3;

    typedef logic [PWM_VAL_W-1:0] pwm_val_t;

    typedef enum logic [1:0] {
        CH_RED,
        CH_GREEN,
        CH_BLUE
    } rgb_ch_t;

    // Duties above the period would only waste counter range; saturate at "always on".
    function automatic int unsigned clamp_duty(input int unsigned value,
                                               input int unsigned limit);
        return (value > limit) ? limit : value;
    endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM colour channel: clamps and captures the incoming duty into a shadow register,
// promotes it to the active register on the period load strobe, and drives a registered LED.
module pwm_channel
    import rgb_pkg::*;
#(
    parameter int PWM_INTERVAL = PWM_INTERVAL_DEFAULT,
    parameter int VW           = $clog2(PWM_INTERVAL),
    parameter bit ACTIVE_LOW   = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [VW-1:0] count,
    input  logic          load,
    input  logic          capture,
    input  logic [VW-1:0] duty,
    output logic          led
);

    logic [VW-1:0] duty_clamped;
    logic [VW-1:0] shadow_reg, shadow_next;
    logic [VW-1:0] active_reg, active_next;
    logic          led_reg, led_next;

    always_comb begin
        duty_clamped = VW'(clamp_duty(32'(duty), PWM_INTERVAL));
    end

    always_comb begin
        shadow_next = shadow_reg;
        active_next = active_reg;
        if (capture) begin
            shadow_next = duty_clamped;
        end
        // A capture on the load edge itself goes straight into active.
        if (load) begin
            active_next = capture ? duty_clamped : shadow_reg;
        end
        led_next = (count < active_reg) ^ ACTIVE_LOW;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_reg <= '0;
            active_reg <= '0;
            led_reg    <= ACTIVE_LOW;
        end else begin
            shadow_reg <= shadow_next;
            active_reg <= active_next;
            led_reg    <= led_next;
        end
    end

    assign led = led_reg;

endmodule

// File: rtl/rgb_pwm_driver.sv
// Three-channel fixed-period PWM LED driver with period-boundary duty double-buffering.
// Define RGB_PWM_ACTIVE_LOW_EN to invert the LED pins for common-anode parts.
module rgb_pwm_driver
    import rgb_pkg::*;
#(
    parameter int PWM_INTERVAL = PWM_INTERVAL_DEFAULT,
    parameter int VW           = $clog2(PWM_INTERVAL)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          value_update,
    input  logic [VW-1:0] red_pwm_value,
    input  logic [VW-1:0] green_pwm_value,
    input  logic [VW-1:0] blue_pwm_value,
    output logic          red_led,
    output logic          green_led,
    output logic          blue_led,
    output logic          period_start
);

`ifdef RGB_PWM_ACTIVE_LOW_EN
    localparam bit ACTIVE_LOW = 1'b1;
`else
    localparam bit ACTIVE_LOW = 1'b0;
`endif

    localparam logic [VW-1:0] LAST_COUNT = VW'(PWM_INTERVAL - 1);

    logic [VW-1:0] count_reg, count_next;
    logic          pending_reg, pending_next;
    logic          period_start_reg, period_start_next;
    logic          wrap;
    logic          load;

    logic [VW-1:0] duty_in [NUM_CH];
    logic          led_out [NUM_CH];

    always_comb begin
        wrap              = (count_reg == LAST_COUNT);
        count_next        = wrap ? '0 : count_reg + VW'(1);
        period_start_next = wrap;
        // Load only when there is something new; otherwise active simply holds.
        load              = wrap && (pending_reg || value_update);
        pending_next      = pending_reg;
        if (wrap) begin
            pending_next = 1'b0;
        end else if (value_update) begin
            pending_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg        <= '0;
            pending_reg      <= 1'b0;
            period_start_reg <= 1'b0;
        end else begin
            count_reg        <= count_next;
            pending_reg      <= pending_next;
            period_start_reg <= period_start_next;
        end
    end

    assign duty_in[CH_RED]   = red_pwm_value;
    assign duty_in[CH_GREEN] = green_pwm_value;
    assign duty_in[CH_BLUE]  = blue_pwm_value;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            pwm_channel #(
                .PWM_INTERVAL (PWM_INTERVAL),
                .VW           (VW),
                .ACTIVE_LOW   (ACTIVE_LOW)
            ) u_ch (
                .clk     (clk),
                .rst     (rst),
                .count   (count_reg),
                .load    (load),
                .capture (value_update),
                .duty    (duty_in[gi]),
                .led     (led_out[gi])
            );
        end
    endgenerate

    assign red_led      = led_out[CH_RED];
    assign green_led    = led_out[CH_GREEN];
    assign blue_led     = led_out[CH_BLUE];
    assign period_start = period_start_reg;

endmodule

// File: tb/tb_rgb_pwm_driver.sv
// Directed, table-driven bench for rgb_pwm_driver with a 10-cycle PWM period;
// LED patterns are recorded per period (bit i = LED state reflecting count i).
module tb_rgb_pwm_driver;

    localparam int P  = 10;
    localparam int VW = 4;
`ifdef RGB_PWM_ACTIVE_LOW_EN
    localparam logic INV = 1'b1;
`else
    localparam logic INV = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          value_update = 1'b0;
    logic [VW-1:0] red_pwm_value = '0;
    logic [VW-1:0] green_pwm_value = '0;
    logic [VW-1:0] blue_pwm_value = '0;
    logic          red_led, green_led, blue_led, period_start;

    int tests = 0;
    int fails = 0;
    int tb_cnt = 0;

    rgb_pwm_driver #(.PWM_INTERVAL(P)) dut (
        .clk             (clk),
        .rst             (rst),
        .value_update    (value_update),
        .red_pwm_value   (red_pwm_value),
        .green_pwm_value (green_pwm_value),
        .blue_pwm_value  (blue_pwm_value),
        .red_led         (red_led),
        .green_led       (green_led),
        .blue_led        (blue_led),
        .period_start    (period_start)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         s1;
        logic [3:0] r1, g1, b1;
        int         s2;
        logic [3:0] r2, g2, b2;
        logic [9:0] cur_r, cur_g, cur_b;
        logic [9:0] nxt_r, nxt_g, nxt_b;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            $display("[TB] ok %s = %0h", name, act);
        end
    endtask

    // Advance one clock; mirrors the DUT period counter, ends at the falling edge.
    task automatic tick();
        @(posedge clk);
        if (rst) tb_cnt = 0;
        else     tb_cnt = (tb_cnt + 1) % P;
        @(negedge clk);
    endtask

    // Must be entered with tb_cnt == 1; samples the LEDs for counts 0..9 of one period.
    task automatic run_period(input int s1, input logic [3:0] r1, g1, b1,
                              input int s2, input logic [3:0] r2, g2, b2,
                              output logic [9:0] pr, pg, pb, pps);
        for (int i = 0; i < P; i++) begin
            pr[i]  = red_led ^ INV;
            pg[i]  = green_led ^ INV;
            pb[i]  = blue_led ^ INV;
            pps[i] = period_start;
            if (tb_cnt == s1) begin
                red_pwm_value = r1; green_pwm_value = g1; blue_pwm_value = b1;
                value_update = 1'b1;
            end else if (tb_cnt == s2) begin
                red_pwm_value = r2; green_pwm_value = g2; blue_pwm_value = b2;
                value_update = 1'b1;
            end else begin
                value_update = 1'b0;
            end
            tick();
        end
        value_update = 1'b0;
    endtask

    initial begin
        logic [9:0] pr, pg, pb, pps;

        //            s1 r  g   b  s2  r  g  b  cur_r   cur_g   cur_b   nxt_r   nxt_g   nxt_b
        vecs[0] = '{-1, 0, 0,  0, -1, 0, 0, 0, 10'h000, 10'h000, 10'h000, 10'h000, 10'h000, 10'h000};
        vecs[1] = '{ 4, 3, 10, 0, -1, 0, 0, 0, 10'h000, 10'h000, 10'h000, 10'h007, 10'h3FF, 10'h000};
        vecs[2] = '{-1, 0, 0,  0, -1, 0, 0, 0, 10'h007, 10'h3FF, 10'h000, 10'h007, 10'h3FF, 10'h000};
        vecs[3] = '{ 9, 5, 10, 0, -1, 0, 0, 0, 10'h007, 10'h3FF, 10'h000, 10'h01F, 10'h3FF, 10'h000};
        vecs[4] = '{ 2, 7, 0,  4,  6, 2, 0, 4, 10'h01F, 10'h3FF, 10'h000, 10'h003, 10'h000, 10'h00F};
        vecs[5] = '{ 3, 15, 0, 4, -1, 0, 0, 0, 10'h003, 10'h000, 10'h00F, 10'h3FF, 10'h000, 10'h00F};

        repeat (3) tick();
        check("reset_red",   32'(red_led),   32'(INV));
        check("reset_green", 32'(green_led), 32'(INV));
        check("reset_blue",  32'(blue_led),  32'(INV));
        check("reset_pstart", 32'(period_start), 32'd0);

        rst = 1'b0;
        tick();

        for (int i = 0; i < 6; i++) begin
            run_period(vecs[i].s1, vecs[i].r1, vecs[i].g1, vecs[i].b1,
                       vecs[i].s2, vecs[i].r2, vecs[i].g2, vecs[i].b2, pr, pg, pb, pps);
            check($sformatf("v%0d_cur_red", i),    32'(pr),  32'(vecs[i].cur_r));
            check($sformatf("v%0d_cur_green", i),  32'(pg),  32'(vecs[i].cur_g));
            check($sformatf("v%0d_cur_blue", i),   32'(pb),  32'(vecs[i].cur_b));
            check($sformatf("v%0d_cur_pstart", i), 32'(pps), 32'h200);
            run_period(-1, 4'd0, 4'd0, 4'd0, -1, 4'd0, 4'd0, 4'd0, pr, pg, pb, pps);
            check($sformatf("v%0d_nxt_red", i),    32'(pr),  32'(vecs[i].nxt_r));
            check($sformatf("v%0d_nxt_green", i),  32'(pg),  32'(vecs[i].nxt_g));
            check($sformatf("v%0d_nxt_blue", i),   32'(pb),  32'(vecs[i].nxt_b));
            check($sformatf("v%0d_nxt_pstart", i), 32'(pps), 32'h200);
            check($sformatf("v%0d_pending", i),    32'(dut.pending_reg), 32'd0);
        end

        check("clamp_red_active", 32'(dut.g_ch[0].u_ch.active_reg), 32'd10);

        // Reset in the middle of a period with red constantly on.
        while (tb_cnt != 5) tick();
        rst = 1'b1;
        tick();
        check("midrst_red",    32'(red_led),   32'(INV));
        check("midrst_green",  32'(green_led), 32'(INV));
        check("midrst_blue",   32'(blue_led),  32'(INV));
        check("midrst_pstart", 32'(period_start), 32'd0);
        check("midrst_count",  32'(dut.count_reg), 32'd0);
        check("midrst_pending", 32'(dut.pending_reg), 32'd0);
        rst = 1'b0;
        tick();
        for (int k = 0; k < 2; k++) begin
            run_period(-1, 4'd0, 4'd0, 4'd0, -1, 4'd0, 4'd0, 4'd0, pr, pg, pb, pps);
            check($sformatf("postrst%0d_red", k),    32'(pr),  32'h000);
            check($sformatf("postrst%0d_green", k),  32'(pg),  32'h000);
            check($sformatf("postrst%0d_blue", k),   32'(pb),  32'h000);
            check($sformatf("postrst%0d_pstart", k), 32'(pps), 32'h200);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
